breathing_pwm_multi: RTL



---
 rtl/breathing_pwm_pkg.sv | 21 ++
 rtl/breathing_ramp.sv | 74 +++++++
 rtl/breathing_pwm_multi.sv | 85 ++++++++
 3 files changed

// File: rtl/breathing_pwm_pkg.sv
// Shared types and helpers for the multi-channel breathing PWM block.
// Mode encoding matches the 2-bit mode input.
package breathing_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_TRI  = 2'd0,
        MODE_SAW  = 2'd1,
        MODE_HOLD = 2'd2,
        MODE_OFF  = 2'd3
    } mode_e;

    function automatic int max_duty(input int width);
        return (1 << width) - 1;
    endfunction

    // Reset duty of channel i: channels are spread evenly over the duty range.
    function automatic int phase_init(input int i, input int ch, input int width);
        return i * (max_duty(width) / ch);
    endfunction

endpackage

// File: rtl/breathing_ramp.sv
// Per-channel duty ramp: triangle, sawtooth, hold or off.
// Duty only moves on PWM period boundaries so a period is never split.
module breathing_ramp
    import breathing_pwm_pkg::*;
#(
    parameter int DUTY_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              period_end_i,
    input  logic [1:0]        mode_i,
    input  logic [DUTY_W-1:0] hold_duty_i,
    input  logic [DUTY_W-1:0] init_i,
    output logic [DUTY_W-1:0] duty_o
);

    localparam logic [DUTY_W-1:0] MAX = DUTY_W'(max_duty(DUTY_W));
    localparam logic [DUTY_W-1:0] ONE = DUTY_W'(1);

    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              up_q, up_d;
    mode_e             mode;

    assign mode = mode_e'(mode_i);

    always_comb begin
        duty_d = duty_q;
        up_d   = up_q;
        if (period_end_i) begin
            case (mode)
                MODE_HOLD: duty_d = hold_duty_i;
                MODE_TRI: begin
                    if (tick_i) begin
                        if (up_q) begin
                            if (duty_q == MAX) begin
                                up_d   = 1'b0;
                                duty_d = MAX - ONE;
                            end else begin
                                duty_d = duty_q + ONE;
                            end
                        end else begin
                            if (duty_q == '0) begin
                                up_d   = 1'b1;
                                duty_d = ONE;
                            end else begin
                                duty_d = duty_q - ONE;
                            end
                        end
                    end
                end
                MODE_SAW: begin
                    if (tick_i) begin
                        duty_d = (duty_q == MAX) ? '0 : duty_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= init_i;
            up_q   <= 1'b1;
        end else begin
            duty_q <= duty_d;
            up_q   <= up_d;
        end
    end

    assign duty_o = duty_q;

endmodule

// File: rtl/breathing_pwm_multi.sv
// Multi-channel breathing-LED PWM: shared period counter and prescaler,
// one ramp and one registered comparator per channel.
module breathing_pwm_multi
    import breathing_pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DUTY_W   = 7,
    parameter int PRESC_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [PRESC_W-1:0]         presc,
    input  logic [DUTY_W-1:0]          hold_duty,
    output logic [CHANNELS-1:0]        pwm,
    output logic [CHANNELS*DUTY_W-1:0] duty,
    output logic                       period_end
);

    localparam logic [DUTY_W-1:0] MAX    = DUTY_W'(max_duty(DUTY_W));
    localparam logic [DUTY_W-1:0] ONE    = DUTY_W'(1);
    localparam logic [DUTY_W-1:0] LAST   = MAX - ONE;

    logic [DUTY_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [DUTY_W-1:0]   duty_w [CHANNELS];
    logic                tick;
    logic                drive_on;

    assign period_end = en && (cnt_q == LAST);
    // Comparing with >= lets a lowered presc take effect at the very next period end.
    assign tick       = period_end && (presc_cnt_q >= presc);
    assign drive_on   = en && (mode_e'(mode) != MODE_OFF);

    always_comb begin
        cnt_d       = cnt_q;
        presc_cnt_d = presc_cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
        if (period_end) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = drive_on && (cnt_q < duty_w[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            presc_cnt_q <= '0;
            pwm_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_q       <= pwm_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        breathing_ramp #(
            .DUTY_W(DUTY_W)
        ) u_ramp (
            .clk          (clk),
            .rst          (rst),
            .tick_i       (tick),
            .period_end_i (period_end),
            .mode_i       (mode),
            .hold_duty_i  (hold_duty),
            .init_i       (DUTY_W'(phase_init(g, CHANNELS, DUTY_W))),
            .duty_o       (duty_w[g])
        );
        assign duty[g*DUTY_W +: DUTY_W] = duty_w[g];
    end

    assign pwm = pwm_q;

endmodule
